// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: result bundle of the PS/2 keyboard receiver.
//   rx_byte/rx_strobe        raw byte stream (good frames only)
//   key_code/key_pressed/
//   key_extended/key_strobe  folded key events for the keyboard mapper
//   parity_err/frame_err     one-cycle error pulses
// master = receiver (drives), slave = consumer.
interface ps2_kbd_rx_if;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       key_strobe;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output rx_byte, rx_strobe, key_code, key_pressed, key_extended,
           key_strobe, parity_err, frame_err
  );
  modport slave (
    input  rx_byte, rx_strobe, key_code, key_pressed, key_extended,
           key_strobe, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver and scancode prefix folder.
//   clk_sys   system clock
//   reset_n   async active-low reset
//   ps2_clk   PS/2 clock (idles high)
//   ps2_data  PS/2 data
//   rx        ps2_kbd_rx_if.master: byte stream, key events, error pulses
// Frames are 11 bits (start, 8 data LSB first, odd parity, stop), sampled on
// filtered falling edges of ps2_clk. E0/F0 prefixes set flags that fold into
// the next key event; E1 (Pause) suppresses the following 7 bytes.
module ps2_kbd_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4000
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master rx
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall, din;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          ext_f, rel_f;
  logic [2:0]    skip;

  assign din  = dat_sync[1];
  // Edge fires in the cycle the filtered clock flips from 1 to 0.
  assign fall = filt_clk && !clk_sync[1] && (filt_cnt == FW'(FILTER - 1));

  // Synchronisers reset to the idle-high level so release never fakes an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_sync[1] == filt_clk)
        filt_cnt <= '0;
      else if (filt_cnt == FW'(FILTER - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else
        filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      par             <= 1'b0;
      to_cnt          <= '0;
      ext_f           <= 1'b0;
      rel_f           <= 1'b0;
      skip            <= '0;
      rx.rx_byte      <= '0;
      rx.rx_strobe    <= 1'b0;
      rx.key_code     <= '0;
      rx.key_pressed  <= 1'b0;
      rx.key_extended <= 1'b0;
      rx.key_strobe   <= 1'b0;
      rx.parity_err   <= 1'b0;
      rx.frame_err    <= 1'b0;
    end else begin
      rx.rx_strobe  <= 1'b0;
      rx.key_strobe <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;

      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      if (state != IDLE && to_cnt == TW'(TIMEOUT)) begin
        rx.frame_err <= 1'b1;
        state        <= IDLE;
        ext_f        <= 1'b0;
        rel_f        <= 1'b0;
        skip         <= '0;
      end else if (fall) begin
        case (state)
          IDLE: if (!din) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          default: begin  // STOP
            state <= IDLE;
            if (!din || !(^{shreg, par})) begin
              rx.frame_err  <= !din;
              rx.parity_err <= din;
              ext_f         <= 1'b0;
              rel_f         <= 1'b0;
              skip          <= '0;
            end else begin
              rx.rx_byte   <= shreg;
              rx.rx_strobe <= 1'b1;
              // Pause skipping outranks prefix decoding so its embedded
              // E1/F0 bytes cannot leak into later key events.
              if (skip != 3'd0)
                skip <= skip - 1'b1;
              else begin
                case (shreg)
                  8'hE0: ext_f <= 1'b1;
                  8'hF0: rel_f <= 1'b1;
                  8'hE1: skip  <= 3'd7;
                  8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                  default: begin
                    rx.key_code     <= shreg;
                    rx.key_pressed  <= ~rel_f;
                    rx.key_extended <= ext_f;
                    rx.key_strobe   <= 1'b1;
                    ext_f           <= 1'b0;
                    rel_f           <= 1'b0;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;
  localparam int TIMEOUT = 4000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_rx_if rx_if ();

  ps2_kbd_rx #(.FILTER(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx      (rx_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } key_t;

  logic [7:0] rxq[$];
  key_t       keyq[$];
  logic [1:0] errq[$];   // {frame, parity}

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_rx(input logic [7:0] b);
    rxq.push_back(b);
  endtask
  task automatic exp_key(input logic [7:0] c, input logic p, input logic e);
    keyq.push_back({c, p, e});
  endtask
  task automatic exp_err(input logic [1:0] k);
    errq.push_back(k);
  endtask

  // Monitor: pops one expectation per DUT output pulse.
  logic [7:0] m_b;
  key_t       m_k;
  logic [1:0] m_e;
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (rx_if.rx_strobe) begin
        if (rxq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_unexpected: got byte %0h expected none", rx_if.rx_byte);
        end else begin
          m_b = rxq.pop_front();
          chk("rx_byte", rx_if.rx_byte, m_b);
        end
      end
      if (rx_if.key_strobe) begin
        chk("key_with_rx", rx_if.rx_strobe, 1);
        if (keyq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL key_unexpected: got code %0h expected none", rx_if.key_code);
        end else begin
          m_k = keyq.pop_front();
          chk("key_event", {rx_if.key_code, rx_if.key_pressed, rx_if.key_extended}, m_k);
        end
      end
      if (rx_if.parity_err || rx_if.frame_err) begin
        if (errq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL err_unexpected: got {frame,parity}=%b expected none",
                   {rx_if.frame_err, rx_if.parity_err});
        end else begin
          m_e = errq.pop_front();
          chk("err_kind", {rx_if.frame_err, rx_if.parity_err}, m_e);
        end
      end
    end
  end

  // PS/2 device timing: data set mid-high, clock low 40 cycles, high 40.
  task automatic send_bits(input logic [10:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = v[i];
      repeat (20) @(posedge clk_sys);
      ps2_clk = 1'b0;
      repeat (40) @(posedge clk_sys);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk_sys);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    logic       p;
    logic [10:0] v;
    p = ~(^b) ^ flip;
    v = {stop, p, b, 1'b0};
    send_bits(v, 11);
    ps2_data = 1'b1;
    repeat (60) @(posedge clk_sys);
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk_sys);
    chk({tag, "_rx_byte"}, rx_if.rx_byte, 0);
    chk({tag, "_key_code"}, rx_if.key_code, 0);
    chk({tag, "_flags"}, {rx_if.rx_strobe, rx_if.key_pressed, rx_if.key_extended,
                          rx_if.key_strobe, rx_if.parity_err, rx_if.frame_err}, 0);
  endtask

  initial begin
    repeat (5) @(posedge clk_sys);
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);

    // Plain make code
    exp_rx(8'h1C); exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Extended break, then plain make
    exp_rx(8'hE0); exp_rx(8'hF0); exp_rx(8'h75); exp_key(8'h75, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    exp_rx(8'h1C); exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Parity errors; second one must clear the pending F0
    exp_err(2'b01);
    send_frame(8'h1C, 1'b1, 1'b1);
    exp_rx(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1);
    exp_err(2'b01);
    send_frame(8'h33, 1'b1, 1'b1);
    exp_rx(8'h1C); exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Bad stop bit
    exp_err(2'b10);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Raw-only byte keeps the F0 flag
    exp_rx(8'hF0); exp_rx(8'hAA); exp_rx(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Timeout after 5 bits (start + 4 data bits of 2A)
    exp_err(2'b10);
    send_bits(11'b000_0101_0100, 5);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 10) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("timeout_err_seen", errq.size(), 0);
    exp_rx(8'h2A); exp_key(8'h2A, 1'b1, 1'b0);
    send_frame(8'h2A, 1'b0, 1'b1);

    // 3-cycle clock glitch with data low must not start a frame
    ps2_data = 1'b0;
    repeat (5) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (5) @(posedge clk_sys);
    ps2_data = 1'b1;
    repeat (40) @(posedge clk_sys);

    // Pause sequence swallowed, then plain make
    begin
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) begin
        exp_rx(pause_seq[i]);
        send_frame(pause_seq[i], 1'b0, 1'b1);
      end
    end
    exp_rx(8'h1C); exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    // Reset mid-frame (6 bits of 16), then a clean 16
    send_bits({1'b1, ~(^8'h16), 8'h16, 1'b0}, 6);
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    chk_zero("midreset");
    ps2_data = 1'b1;
    repeat (3) @(posedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
    exp_rx(8'h16); exp_key(8'h16, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1);

    repeat (100) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rx_left", rxq.size(), 0);
    chk("key_left", keyq.size(), 0);
    chk("err_left", errq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
